// File: rtl/booth_r4_control.sv
// ---------------------------------------------------------------------------
// booth_r4_control
//
// Radix-4 Booth sequencer and register file for a shift-and-add multiplier.
// It holds the multiplicand (M), the accumulator (HI) and the multiplier/low
// product (LO). In each CALC cycle it recodes two multiplier bits plus the
// extra Booth bit into an operation code for an external add/subtract stage.
// It then takes that stage's result back and arithmetic-shifts {HI, LO} right
// by two. After N/2 iterations the signed 2N-bit product is registered and
// DONE pulses for one cycle.
//
// Parameters
//   N        operand width in bits (even, >= 4). The companion adder works
//            on N+2-bit values.
//
// Ports
//   CLOCK    in   1     rising-edge clock
//   RESET    in   1     asynchronous active-high reset
//   START    in   1     start request, honoured only in IDLE
//   A        in   N     signed multiplicand, sampled with START
//   B        in   N     signed multiplier, sampled with START
//   ADD_OUT  in   N+2   adder result for REG_HI, REG_M and OP_MODE
//   OP_MODE  out  2     00 HI+M, 01 HI-M, 10 HI+2M, 11 HI-2M
//   REG_M    out  N+2   sign-extended multiplicand register
//   REG_HI   out  N+2   accumulator register
//   PRODUCT  out  2N    signed product, held until the next completion
//   BUSY     out  1     high while iterating
//   DONE     out  1     one-cycle completion pulse
// ---------------------------------------------------------------------------
module booth_r4_control #(
    parameter int N = 8
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           START,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [N+1:0]   ADD_OUT,
    output logic [1:0]     OP_MODE,
    output logic [N+1:0]   REG_M,
    output logic [N+1:0]   REG_HI,
    output logic [2*N-1:0] PRODUCT,
    output logic           BUSY,
    output logic           DONE
);

    localparam int W  = N + 2;
    localparam int CW = $clog2(N / 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    // Booth digit recode. Result bit 2 flags a non-zero digit, so the adder
    // result is used. Bits 1:0 are the adder operation code.
    function automatic logic [2:0] booth_recode(input logic [2:0] digit);
        logic [2:0] rec;
        case (digit)
            3'b001, 3'b010: rec = 3'b1_00;  // +M
            3'b011:         rec = 3'b1_10;  // +2M
            3'b100:         rec = 3'b1_11;  // -2M
            3'b101, 3'b110: rec = 3'b1_01;  // -M
            default:        rec = 3'b0_00;  // 000 / 111: digit 0
        endcase
        return rec;
    endfunction

    state_t         r_state;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_q;
    logic [CW-1:0]  r_count;
    logic [2*N-1:0] r_product;
    logic           r_busy;
    logic           r_done;

    logic [2:0]     w_digit;
    logic [2:0]     w_rec;
    logic [1:0]     w_op;
    logic           w_add_en;
    logic [W-1:0]   w_sum;
    logic [W-1:0]   w_hi_next;
    logic [N-1:0]   w_lo_next;
    logic           w_last;

    // Recode the current digit and select the adder result or the unchanged HI.
    always_comb begin
        w_digit  = {r_lo[1:0], r_q};
        w_rec    = booth_recode(w_digit);
        w_op     = 2'b00;
        w_add_en = 1'b0;
        if (r_state == S_CALC) begin
            w_op     = w_rec[1:0];
            w_add_en = w_rec[2];
        end else begin
            w_op     = 2'b00;
            w_add_en = 1'b0;
        end
        if (w_add_en) begin
            w_sum = ADD_OUT;
        end else begin
            w_sum = r_hi;
        end
        // Arithmetic shift of {sum, LO} right by two. HI has two spare sign
        // bits, so replicating sum's MSB keeps the value exact even for
        // -2^(N-1) * -2^(N-1).
        w_hi_next = {w_sum[W-1], w_sum[W-1], w_sum[W-1:2]};
        w_lo_next = {w_sum[1:0], r_lo[N-1:2]};
        w_last    = (r_count == CW'(N / 2 - 1));
    end

    // Sequencer FSM and datapath registers, including the registered status outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_m       <= {W{1'b0}};
            r_hi      <= {W{1'b0}};
            r_lo      <= {N{1'b0}};
            r_q       <= 1'b0;
            r_count   <= {CW{1'b0}};
            r_product <= {(2*N){1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_m     <= {{2{A[N-1]}}, A};
                        r_hi    <= {W{1'b0}};
                        r_lo    <= B;
                        r_q     <= 1'b0;
                        r_count <= {CW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_hi    <= w_hi_next;
                    r_lo    <= w_lo_next;
                    r_q     <= r_lo[1];
                    r_count <= r_count + CW'(1'b1);
                    if (w_last) begin
                        // Final iteration: capture the product from the next-state
                        // values so that it is valid on the edge that enters FIN.
                        r_product <= {w_hi_next[N-1:0], w_lo_next};
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_state   <= S_CALC;
                    end
                end
                S_FIN: begin
                    // START is deliberately ignored here; the minimum issue
                    // interval is N/2+2 cycles.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign OP_MODE = w_op;
    assign REG_M   = r_m;
    assign REG_HI  = r_hi;
    assign PRODUCT = r_product;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

endmodule

// File: tb/tb_booth_r4_control.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_control
//
// Directed and random checks of booth_r4_control with N=8. The bench supplies
// the companion adder (HI +/- M or 2M) combinationally. Expected products are
// hand-computed constants or the bench's own A*B. Expected OP_MODE values are
// derived from the overlapping bit triplets of B.
// ---------------------------------------------------------------------------
module tb_booth_r4_control;

    localparam int N = 8;

    logic           CLOCK = 1'b0;
    logic           RESET = 1'b1;
    logic           START = 1'b0;
    logic [N-1:0]   A = 8'd0;
    logic [N-1:0]   B = 8'd0;
    logic [N+1:0]   ADD_OUT;
    logic [1:0]     OP_MODE;
    logic [N+1:0]   REG_M;
    logic [N+1:0]   REG_HI;
    logic [2*N-1:0] PRODUCT;
    logic           BUSY;
    logic           DONE;

    int n_checks = 0;
    int n_fail   = 0;

    booth_r4_control #(.N(N)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .START   (START),
        .A       (A),
        .B       (B),
        .ADD_OUT (ADD_OUT),
        .OP_MODE (OP_MODE),
        .REG_M   (REG_M),
        .REG_HI  (REG_HI),
        .PRODUCT (PRODUCT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLOCK = ~CLOCK;

    // Companion adder stage.
    always_comb begin
        case (OP_MODE)
            2'b00:   ADD_OUT = REG_HI + REG_M;
            2'b01:   ADD_OUT = REG_HI - REG_M;
            2'b10:   ADD_OUT = REG_HI + (REG_M << 1);
            2'b11:   ADD_OUT = REG_HI - (REG_M << 1);
            default: ADD_OUT = 10'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected op code for CALC iteration i from B's triplet {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic [1:0] exp_op(input logic [7:0] b, input int i);
        logic [2:0] d;
        logic       prev;
        prev = (i == 0) ? 1'b0 : b[2*i-1];
        d    = {b[2*i+1], b[2*i], prev};
        case (d)
            3'b001, 3'b010: return 2'b00;
            3'b011:         return 2'b10;
            3'b100:         return 2'b11;
            3'b101, 3'b110: return 2'b01;
            default:        return 2'b00;
        endcase
    endfunction

    // One full multiplication with per-cycle BUSY/DONE/OP_MODE checks.
    // It returns one cycle after FIN, so back-to-back calls issue at N/2+2 cycles.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [9:0] m_sext;
        m_sext = {{2{a[7]}}, a};
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        check("reg_m_sext", 32'(REG_M), 32'(m_sext));
        for (int i = 0; i < N / 2; i++) begin
            check("busy_calc", 32'(BUSY), 32'd1);
            check("done_calc", 32'(DONE), 32'd0);
            check("op_mode", 32'(OP_MODE), 32'(exp_op(b, i)));
            @(posedge CLOCK); #1;
        end
        check("done_fin", 32'(DONE), 32'd1);
        check("busy_fin", 32'(BUSY), 32'd0);
        check("op_fin", 32'(OP_MODE), 32'd0);
        check("product", 32'(PRODUCT), 32'(exp));
        @(posedge CLOCK); #1;
        check("done_idle", 32'(DONE), 32'd0);
        check("product_held", 32'(PRODUCT), 32'(exp));
    endtask

    initial begin
        logic [7:0]         ra;
        logic [7:0]         rb;
        logic signed [15:0] rp;

        // Reset state.
        #2;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_product", 32'(PRODUCT), 32'd0);
        check("rst_op", 32'(OP_MODE), 32'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b0;

        // Directed vectors.
        run_mul(8'd3,   8'd5,   16'h000F);
        run_mul(8'h80,  8'h80,  16'h4000);
        run_mul(8'h80,  8'h7F,  16'hC080);
        run_mul(8'h7F,  8'h7F,  16'h3F01);
        run_mul(8'hFF,  8'hFF,  16'h0001);
        run_mul(8'd0,   8'hB3,  16'h0000);
        run_mul(8'hF9,  8'd6,   16'hFFD6);

        // START pulsed during CALC and held in FIN is ignored.
        A = 8'd3; B = 8'd5; START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        @(posedge CLOCK); #1;
        A = 8'd100; B = 8'hFD; START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        check("ign_busy", 32'(BUSY), 32'd1);
        check("ign_reg_m", 32'(REG_M), 32'd3);
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;
        check("ign_done", 32'(DONE), 32'd1);
        check("ign_product", 32'(PRODUCT), 32'h000F);
        START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        check("ign_fin_done", 32'(DONE), 32'd0);
        check("ign_fin_busy", 32'(BUSY), 32'd0);
        @(posedge CLOCK); #1;
        check("ign_idle_busy", 32'(BUSY), 32'd0);
        check("ign_idle_done", 32'(DONE), 32'd0);
        check("ign_product_held", 32'(PRODUCT), 32'h000F);

        // Reset asserted mid-CALC clears everything at once.
        A = 8'd3; B = 8'd5; START = 1'b1;
        @(posedge CLOCK); #1;
        START = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        #1;
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_done", 32'(DONE), 32'd0);
        check("mid_rst_op", 32'(OP_MODE), 32'd0);
        check("mid_rst_m", 32'(REG_M), 32'd0);
        check("mid_rst_hi", 32'(REG_HI), 32'd0);
        check("mid_rst_product", 32'(PRODUCT), 32'd0);
        #1;
        RESET = 1'b0;
        run_mul(8'hF9, 8'd6, 16'hFFD6);

        // Random signed pairs against the bench's own multiply.
        repeat (1000) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = $signed(ra) * $signed(rb);
            run_mul(ra, rb, rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
